// File: rtl/rf_stack_ctrl_if.sv
// rf_stack_ctrl_if -- request/strobe bundle between a call/return requester
// and the register-file stack controller.
//
// Signals:
//   call_req, ret_req   level requests from the requester, held until ctrl_done
//   rf_stack_push/pop   single-cycle strobes to the register file
//   rf_stack_pointer    stack pointer presented with the strobes
//   ctrl_busy           controller is not idle
//   ctrl_done           one-cycle completion pulse (accepted or rejected)
//   stack_full/empty    stack pointer at DEPTH / at zero
//   stack_err           sticky overflow/underflow flag
//   stack_hwm           stack pointer high-water mark (0 when tracking is off)
//
// Modports: master = requester side, slave = controller side.
interface rf_stack_ctrl_if #(
    parameter int PC_WIDTH = 6
);
    logic                call_req;
    logic                ret_req;
    logic                rf_stack_push;
    logic                rf_stack_pop;
    logic [PC_WIDTH-1:0] rf_stack_pointer;
    logic                ctrl_busy;
    logic                ctrl_done;
    logic                stack_full;
    logic                stack_empty;
    logic                stack_err;
    logic [PC_WIDTH-1:0] stack_hwm;

    modport master (
        output call_req, ret_req,
        input  rf_stack_push, rf_stack_pop, rf_stack_pointer, ctrl_busy,
               ctrl_done, stack_full, stack_empty, stack_err, stack_hwm
    );

    modport slave (
        input  call_req, ret_req,
        output rf_stack_push, rf_stack_pop, rf_stack_pointer, ctrl_busy,
               ctrl_done, stack_full, stack_empty, stack_err, stack_hwm
    );
endinterface

// File: rtl/rf_stack_ctrl.sv
// rf_stack_ctrl -- saves/restores register-file contexts on a hardware stack.
//
// A call pushes the current context (PUSH strobe at pointer SP, then SP+1);
// a return waits one read-latency cycle then pops (POP strobe at pointer SP,
// then SP-1). Overflow/underflow requests are rejected, set the sticky error
// flag and still complete with ctrl_done.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rf_stack_ctrl_if.slave (requests in, strobes/status out)
//
// Parameters:
//   PC_WIDTH  stack pointer width
//   DEPTH     maximum number of saved contexts (1 .. 2**PC_WIDTH-1)
//
// Optional feature: define RF_STACK_CTRL_HWM_EN to track the SP high-water
// mark on stack_hwm; otherwise stack_hwm is constant zero.
module rf_stack_ctrl #(
    parameter int PC_WIDTH = 6,
    parameter int DEPTH    = 32
) (
    input  logic            clk,
    input  logic            rst,
    rf_stack_ctrl_if.slave  bus
);
    localparam logic [PC_WIDTH-1:0] DEPTH_SP = PC_WIDTH'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_RD,
        POP,
        REJ
    } state_t;

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] sp_reg, sp_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    // Set on every completion; blocks re-acceptance until both requests
    // have been seen low in IDLE, so a held request cannot fire twice.
    logic                lock_reg, lock_next;
    logic                push, pop;
    logic                full, empty;

    assign full  = (sp_reg == DEPTH_SP);
    assign empty = (sp_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sp_reg    <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            lock_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            lock_reg  <= lock_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sp_next    = sp_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        lock_next  = lock_reg;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (lock_reg) begin
                    if (!bus.call_req && !bus.ret_req) begin
                        lock_next = 1'b0;
                    end
                end else if (bus.call_req) begin
                    // call has priority over a simultaneous ret
                    state_next = full ? REJ : PUSH;
                end else if (bus.ret_req) begin
                    state_next = empty ? REJ : POP_RD;
                end
            end
            PUSH: begin
                push       = 1'b1;
                sp_next    = sp_reg + PC_WIDTH'(1);
                state_next = IDLE;
                done_next  = 1'b1;
                lock_next  = 1'b1;
            end
            POP_RD: begin
                // stack memory read latency at address SP
                state_next = POP;
            end
            POP: begin
                pop        = 1'b1;
                sp_next    = sp_reg - PC_WIDTH'(1);
                state_next = IDLE;
                done_next  = 1'b1;
                lock_next  = 1'b1;
            end
            REJ: begin
                err_next   = 1'b1;
                state_next = IDLE;
                done_next  = 1'b1;
                lock_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rf_stack_push    = push;
    assign bus.rf_stack_pop     = pop;
    assign bus.rf_stack_pointer = sp_reg;
    assign bus.ctrl_busy        = (state_reg != IDLE);
    assign bus.ctrl_done        = done_reg;
    assign bus.stack_full       = full;
    assign bus.stack_empty      = empty;
    assign bus.stack_err        = err_reg;

`ifdef RF_STACK_CTRL_HWM_EN
    logic [PC_WIDTH-1:0] hwm_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_reg <= '0;
        end else if (sp_next > hwm_reg) begin
            hwm_reg <= sp_next;
        end
    end

    assign bus.stack_hwm = hwm_reg;
`else
    assign bus.stack_hwm = '0;
`endif

endmodule

// File: tb/tb_rf_stack_ctrl.sv
`timescale 1ns/1ps
module tb_rf_stack_ctrl;
    localparam int PW = 6;
    localparam int D1 = 4;
    localparam int D2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_stack_ctrl_if #(.PC_WIDTH(PW)) bus ();
    rf_stack_ctrl_if #(.PC_WIDTH(PW)) bus2 ();

    rf_stack_ctrl #(.PC_WIDTH(PW), .DEPTH(D1)) dut (.clk(clk), .rst(rst), .bus(bus));
    rf_stack_ctrl #(.PC_WIDTH(PW), .DEPTH(D2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model of the main instance: stack depth, sticky error, max depth.
    int m_sp  = 0;
    bit m_err = 1'b0;
    int m_hwm = 0;

    function automatic int exp_hwm();
`ifdef RF_STACK_CTRL_HWM_EN
        return m_hwm;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.call_req = 1'b0; bus.ret_req = 1'b0;
        bus2.call_req = 1'b0; bus2.ret_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_sp = 0; m_err = 1'b0; m_hwm = 0;
    endtask

    // One request on the main instance, held well past done, then released.
    task automatic do_req(input bit c, input bit r);
        int kind;      // 0 reject, 1 push, 2 pop
        int exp_lat;
        int exp_ptr;
        int push_cnt = 0, pop_cnt = 0, done_cnt = 0, both_cnt = 0;
        int push_n = -1, pop_n = -1, done_n = -1;
        logic [PW-1:0] push_ptr = '0, pop_ptr = '0;

        exp_ptr = m_sp;
        if (c) begin
            if (m_sp < D1) begin kind = 1; exp_lat = 2; m_sp = m_sp + 1; end
            else begin kind = 0; exp_lat = 2; m_err = 1'b1; end
        end else begin
            if (m_sp > 0) begin kind = 2; exp_lat = 3; m_sp = m_sp - 1; end
            else begin kind = 0; exp_lat = 2; m_err = 1'b1; end
        end
        if (m_sp > m_hwm) m_hwm = m_sp;

        @(negedge clk);
        bus.call_req = c; bus.ret_req = r;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.rf_stack_push === 1'b1) begin push_cnt++; push_n = n; push_ptr = bus.rf_stack_pointer; end
            if (bus.rf_stack_pop === 1'b1) begin pop_cnt++; pop_n = n; pop_ptr = bus.rf_stack_pointer; end
            if (bus.rf_stack_push === 1'b1 && bus.rf_stack_pop === 1'b1) both_cnt++;
            if (bus.ctrl_done === 1'b1) begin done_cnt++; if (done_n < 0) done_n = n; end
        end
        bus.call_req = 1'b0; bus.ret_req = 1'b0;

        $display("txn %0d call=%0d ret=%0d kind=%0d sp=%0d done_at=%0d err=%0b",
                 txn, c, r, kind, bus.rf_stack_pointer, done_n, bus.stack_err);
        txn++;

        checks++;
        if (push_cnt != (kind == 1 ? 1 : 0)) begin
            errors++; $display("FAIL push_count txn %0d got %0d want %0d", txn, push_cnt, (kind == 1 ? 1 : 0));
        end
        checks++;
        if (pop_cnt != (kind == 2 ? 1 : 0)) begin
            errors++; $display("FAIL pop_count txn %0d got %0d want %0d", txn, pop_cnt, (kind == 2 ? 1 : 0));
        end
        checks++;
        if (both_cnt != 0) begin
            errors++; $display("FAIL both_strobes txn %0d got %0d want 0", txn, both_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_n != exp_lat) begin
            errors++; $display("FAIL done txn %0d got count %0d at %0d want count 1 at %0d", txn, done_cnt, done_n, exp_lat);
        end
        if (kind == 1) begin
            checks++;
            if (push_n != 1 || push_ptr !== PW'(exp_ptr)) begin
                errors++; $display("FAIL push_slot txn %0d got cyc %0d ptr %0d want cyc 1 ptr %0d", txn, push_n, push_ptr, exp_ptr);
            end
        end
        if (kind == 2) begin
            checks++;
            if (pop_n != 2 || pop_ptr !== PW'(exp_ptr)) begin
                errors++; $display("FAIL pop_slot txn %0d got cyc %0d ptr %0d want cyc 2 ptr %0d", txn, pop_n, pop_ptr, exp_ptr);
            end
        end
        checks++;
        if (bus.rf_stack_pointer !== PW'(m_sp)) begin
            errors++; $display("FAIL sp txn %0d got %0d want %0d", txn, bus.rf_stack_pointer, m_sp);
        end
        checks++;
        if (bus.stack_err !== m_err) begin
            errors++; $display("FAIL err txn %0d got %0b want %0b", txn, bus.stack_err, m_err);
        end
        checks++;
        if (bus.stack_full !== (m_sp == D1) || bus.stack_empty !== (m_sp == 0)) begin
            errors++; $display("FAIL flags txn %0d got full %0b empty %0b want %0b %0b", txn,
                               bus.stack_full, bus.stack_empty, (m_sp == D1), (m_sp == 0));
        end
        checks++;
        if (bus.stack_hwm !== PW'(exp_hwm())) begin
            errors++; $display("FAIL hwm txn %0d got %0d want %0d", txn, bus.stack_hwm, exp_hwm());
        end
        checks++;
        if (bus.ctrl_busy !== 1'b0) begin
            errors++; $display("FAIL busy txn %0d got %0b want 0", txn, bus.ctrl_busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.rf_stack_push, bus.rf_stack_pop, bus.ctrl_busy, bus.ctrl_done, bus.stack_full, bus.stack_err} !== 6'b0) begin
            errors++; $display("FAIL reset_zero got push %0b pop %0b busy %0b done %0b full %0b err %0b want all 0",
                               bus.rf_stack_push, bus.rf_stack_pop, bus.ctrl_busy, bus.ctrl_done, bus.stack_full, bus.stack_err);
        end
        checks++;
        if (bus.rf_stack_pointer !== '0 || bus.stack_empty !== 1'b1 || bus.stack_hwm !== '0) begin
            errors++; $display("FAIL reset_sp got sp %0d empty %0b hwm %0d want 0 1 0",
                               bus.rf_stack_pointer, bus.stack_empty, bus.stack_hwm);
        end
    endtask

    task automatic test_single_call();
        do_reset();
        do_req(1'b1, 1'b0);
    endtask

    task automatic test_calls_then_ret();
        do_reset();
        repeat (3) do_req(1'b1, 1'b0);
        do_req(1'b0, 1'b1);
    endtask

    task automatic test_underflow();
        do_reset();
        do_req(1'b0, 1'b1);
        do_req(1'b1, 1'b0);
    endtask

    task automatic test_both_requests();
        do_reset();
        do_req(1'b1, 1'b0);
        do_req(1'b1, 1'b1);
    endtask

    task automatic test_overflow_depth2();
        int pushes, dones;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pushes = 0; dones = 0;
            @(negedge clk);
            bus2.call_req = 1'b1;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                if (bus2.rf_stack_push === 1'b1) pushes++;
                if (bus2.ctrl_done === 1'b1) dones++;
            end
            bus2.call_req = 1'b0;
            $display("txn d2 call %0d pushes=%0d sp=%0d", k, pushes, bus2.rf_stack_pointer);
            checks++;
            if (pushes != (k < 2 ? 1 : 0) || dones != 1) begin
                errors++; $display("FAIL d2_call%0d got push %0d done %0d want %0d 1", k, pushes, dones, (k < 2 ? 1 : 0));
            end
        end
        checks++;
        if (bus2.stack_full !== 1'b1 || bus2.stack_err !== 1'b1 || bus2.rf_stack_pointer !== PW'(2)) begin
            errors++; $display("FAIL d2_final got full %0b err %0b sp %0d want 1 1 2",
                               bus2.stack_full, bus2.stack_err, bus2.rf_stack_pointer);
        end
    endtask

    task automatic test_reset_in_pop();
        int seen, dones;
        do_reset();
        repeat (3) do_req(1'b1, 1'b0);
        @(negedge clk);
        bus.ret_req = 1'b1;
        seen = 0;
        for (int n = 0; n < 8 && seen == 0; n++) begin
            @(negedge clk);
            if (bus.rf_stack_pop === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            errors++; $display("FAIL rst_pop_wait got no pop want pop within 8 cycles");
        end
        rst = 1'b1;
        bus.ret_req = 1'b0;
        m_sp = 0; m_err = 1'b0; m_hwm = 0;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 4; n++) begin
            if (bus.ctrl_done === 1'b1) dones++;
            @(negedge clk);
        end
        $display("txn rst_in_pop sp=%0d dones=%0d hwm=%0d", bus.rf_stack_pointer, dones, bus.stack_hwm);
        checks++;
        if (bus.rf_stack_pointer !== '0 || dones != 0 || bus.stack_hwm !== '0) begin
            errors++; $display("FAIL rst_pop got sp %0d done %0d hwm %0d want 0 0 0", bus.rf_stack_pointer, dones, bus.stack_hwm);
        end
    endtask

    task automatic test_random();
        int sel;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) do_req(1'b1, 1'b0);
            else if (sel <= 8) do_req(1'b0, 1'b1);
            else do_req(1'b1, 1'b1);
        end
    endtask

    // hwm at depth 3 before a reset is checked through do_req in the three calls
    initial begin
        bus.call_req = 1'b0; bus.ret_req = 1'b0;
        bus2.call_req = 1'b0; bus2.ret_req = 1'b0;
        test_reset();
        test_single_call();
        test_calls_then_ret();
        test_underflow();
        test_both_requests();
        test_overflow_depth2();
        test_reset_in_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
